// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// bit-counter width.
package serial_adder_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// One-bit full adder built from two half-adder cells; the single arithmetic
// slice reused every cycle by serial_adder.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.x(a),  .y(b),   .s(s1), .c(c1));
  half_adder u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));

  // The two half-adder carries can never both be 1, so OR suffices.
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands on start, adds LSB-first one
// bit per clock through a single fa_slice, then pulses done for one cycle.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             bit_s;
  logic             bit_c;
  logic             accept;

  assign accept = start && ((state == IDLE) || (state == DONE));

  fa_slice u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum_r <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      // sum_r is deliberately left alone; it is overwritten bit by bit in RUN.
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= bit_c;
      sum_r <= {bit_s, sum_r[WIDTH-1:1]};
      cnt   <= (cnt == LAST) ? cnt : cnt + CNT_W'(1);
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_r;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8): latency, ripple
// carries, ignored start in RUN, back-to-back operation and mid-run reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (busy === 1'b1 || done === 1'b1))
      check("busy_done_exclusive", 32'(busy & done), 32'd0);
  end

  // Present operands and pulse start across one rising edge; returns on the
  // first negedge after the accept edge (RUN cycle 1, not yet examined).
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'hC3; b = 8'h3C; cin = 1'b1;
  endtask

  // Walk negedges until done (bounded), counting busy cycles (seen already
  // counted), then check result and that done lasts one cycle.
  task automatic finish_op(input string tag, input logic [7:0] es, input logic ec,
                           input int seen, output int t_done);
    int n = seen;
    int i = 0;
    while (done !== 1'b1 && i < 20) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
      i++;
    end
    t_done = cyc;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(n), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int extra_done;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #23;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add and latency.
    start_op(8'h5A, 8'h33, 1'b0);
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    finish_op("t1", 8'h8D, 1'b0, 0, t1);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Carry ripples through every bit.
    start_op(8'hFF, 8'h01, 1'b0);
    finish_op("t2", 8'h00, 1'b1, 0, t1);

    start_op(8'hFF, 8'hFF, 1'b1);
    finish_op("t3", 8'hFF, 1'b1, 0, t1);

    start_op(8'h00, 8'h00, 1'b0);
    finish_op("t4", 8'h00, 1'b0, 0, t1);

    // start during RUN is ignored.
    start_op(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("t5", 8'h30, 1'b0, 3, t1);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra_done++;
      @(negedge clk);
    end
    check("t5_no_second_op", 32'(extra_done), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    finish_op("t6a", 8'h03, 1'b0, 0, t1);
    check("t6_no_idle_between", 32'(busy), 32'd1);
    start = 1'b0;
    finish_op("t6b", 8'h07, 1'b0, 0, t2);
    check("t6_done_spacing", 32'(t2 - t1), 32'd9);

    // Reset in the middle of RUN.
    start_op(8'h0F, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t7_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_done", 32'(done), 32'd0);
    check("t7_rst_sum",  32'(sum),  32'd0);
    check("t7_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) extra_done++;
      @(negedge clk);
    end
    check("t7_no_done_after_abort", 32'(extra_done), 32'd0);
    start_op(8'h01, 8'h01, 1'b0);
    finish_op("t7", 8'h02, 1'b0, 0, t1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
